semaforo_monitor: RTL and testbench

Conflict monitor for the traffic-light controller's signal-head outputs. It samples every 3-bit head code each clock and checks the codes and sequencing: conflicting non-red heads, invalid codes, green→red without yellow, short yellow, and a frozen controller. On the first violation it latches a fault, reports the cause and the head, and drives a flash enable until an operator clear. It sits between the controller outputs and the lamp drivers.

---
 rtl/semaforo_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_semaforo_monitor.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_monitor
// Brief    : Signal-head conflict/sequence monitor; latches the first violation
//            and drives a flash enable until an operator clear.
// Revision : 1.0 - initial release
// ============================================================================
module semaforo_monitor #(
    parameter int N_HEADS    = 14,
    parameter int GLITCH_CYC = 2,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_STABLE = 64,
    parameter int FLASH_DIV  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*N_HEADS-1:0]       lights,
    input  logic [N_HEADS*N_HEADS-1:0] conflict_map,
    input  logic                       clr,
    output logic                       fault,
    output logic [2:0]                 fault_code,
    output logic [4:0]                 fault_head,
    output logic [4:0]                 fault_head_b,
    output logic                       flash
);

    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    localparam logic [2:0] c_F_CONFLICT = 3'd1;
    localparam logic [2:0] c_F_INVALID  = 3'd2;
    localparam logic [2:0] c_F_SKIP     = 3'd3;
    localparam logic [2:0] c_F_SHORT    = 3'd4;
    localparam logic [2:0] c_F_STALL    = 3'd5;

    localparam int c_GW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
    localparam int c_YW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
    localparam int c_SW = $clog2(MAX_STABLE + 1);
    localparam int c_DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [c_GW-1:0] c_GMAX = c_GW'(GLITCH_CYC - 1);
    localparam logic [c_YW-1:0] c_YMAX = c_YW'(MIN_YELLOW);
    localparam logic [c_SW-1:0] c_SMAX = c_SW'(MAX_STABLE);
    localparam logic [c_DW-1:0] c_DMAX = c_DW'(FLASH_DIV - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t r_state, w_state_d;

    logic [3*N_HEADS-1:0] r_lights_q, r_lights_p;
    logic [c_GW-1:0]      r_conf_cnt, r_inv_cnt;
    logic [c_SW-1:0]      r_stall_cnt;
    logic [2:0]           r_code;
    logic [4:0]           r_head_a, r_head_b;
    logic                 r_flash;
    logic [c_DW-1:0]      r_div;

    logic [N_HEADS-1:0] w_nonred, w_invalid, w_skip, w_short, w_diag_unused;
    logic               w_conf_any, w_inv_any, w_conf_hit, w_inv_hit, w_stall_hit;
    logic [4:0]         w_conf_i, w_conf_j, w_hit_a, w_hit_b;
    logic [2:0]         w_hit_code;
    logic               w_latch, w_clear;
    logic               w_bits_unused;

    function automatic logic [4:0] f_first(input logic [N_HEADS-1:0] v);
        f_first = '0;
        for (int k = N_HEADS - 1; k >= 0; k--) begin
            if (v[k]) f_first = 5'(k);
        end
    endfunction

    // Per-head code classification and yellow-duration tracking
    for (genvar gi = 0; gi < N_HEADS; gi++) begin : g_head
        logic [2:0]      w_cur, w_prv;
        logic [c_YW-1:0] r_ycnt;

        assign w_cur = r_lights_q[3*gi +: 3];
        assign w_prv = r_lights_p[3*gi +: 3];
        assign w_nonred[gi]  = (w_cur == c_YEL) || (w_cur == c_GRN);
        assign w_invalid[gi] = !((w_cur == c_RED) || (w_cur == c_YEL) || (w_cur == c_GRN));
        assign w_skip[gi]    = (w_prv == c_GRN) && (w_cur == c_RED);
        assign w_short[gi]   = (w_prv == c_YEL) && (w_cur == c_RED) && (r_ycnt < c_YMAX);
        assign w_diag_unused[gi] = conflict_map[gi*N_HEADS + gi];

        always_ff @(posedge clk) begin
            if (!rst || w_clear) begin
                r_ycnt <= '0;
            end else if (w_cur == c_YEL) begin
                if (r_ycnt != c_YMAX) r_ycnt <= r_ycnt + 1'b1;
            end else begin
                r_ycnt <= '0;
            end
        end
    end

    assign w_bits_unused = ^w_diag_unused;

    // Descending scan so the last match is the lowest (i, j) pair
    always_comb begin
        w_conf_any = 1'b0;
        w_conf_i   = '0;
        w_conf_j   = '0;
        for (int i = N_HEADS - 1; i >= 0; i--) begin
            for (int j = N_HEADS - 1; j > i; j--) begin
                if (w_nonred[i] && w_nonred[j] &&
                    (conflict_map[i*N_HEADS + j] || conflict_map[j*N_HEADS + i])) begin
                    w_conf_any = 1'b1;
                    w_conf_i   = 5'(i);
                    w_conf_j   = 5'(j);
                end
            end
        end
    end

    assign w_inv_any   = |w_invalid;
    assign w_conf_hit  = w_conf_any && (r_conf_cnt == c_GMAX);
    assign w_inv_hit   = w_inv_any && (r_inv_cnt == c_GMAX);
    assign w_stall_hit = (r_stall_cnt == c_SMAX);

    always_comb begin
        w_hit_code = '0;
        w_hit_a    = '0;
        w_hit_b    = '0;
        if (w_conf_hit) begin
            w_hit_code = c_F_CONFLICT;
            w_hit_a    = w_conf_i;
            w_hit_b    = w_conf_j;
        end else if (w_inv_hit) begin
            w_hit_code = c_F_INVALID;
            w_hit_a    = f_first(w_invalid);
        end else if (|w_skip) begin
            w_hit_code = c_F_SKIP;
            w_hit_a    = f_first(w_skip);
        end else if (|w_short) begin
            w_hit_code = c_F_SHORT;
            w_hit_a    = f_first(w_short);
        end else if (w_stall_hit) begin
            w_hit_code = c_F_STALL;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_latch   = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_hit_code != 3'd0) begin
                    w_state_d = ST_FAULT;
                    w_latch   = 1'b1;
                end
            end
            ST_FAULT: begin
                if (clr && !w_conf_any && !w_inv_any) begin
                    w_state_d = ST_RUN;
                    w_clear   = 1'b1;
                end
            end
            default: w_state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lights_q <= {N_HEADS{c_RED}};
            r_lights_p <= {N_HEADS{c_RED}};
        end else begin
            r_lights_q <= lights;
            r_lights_p <= r_lights_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_clear) begin
            r_conf_cnt  <= '0;
            r_inv_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_conf_any)              r_conf_cnt <= '0;
            else if (r_conf_cnt != c_GMAX) r_conf_cnt <= r_conf_cnt + 1'b1;
            if (!w_inv_any)               r_inv_cnt <= '0;
            else if (r_inv_cnt != c_GMAX)  r_inv_cnt <= r_inv_cnt + 1'b1;
            if (r_lights_q != r_lights_p)  r_stall_cnt <= '0;
            else if (r_stall_cnt != c_SMAX) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Flash starts lit on fault entry and toggles every FLASH_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_code   <= '0;
            r_head_a <= '0;
            r_head_b <= '0;
            r_flash  <= 1'b0;
            r_div    <= '0;
        end else if (w_latch) begin
            r_code   <= w_hit_code;
            r_head_a <= w_hit_a;
            r_head_b <= w_hit_b;
            r_flash  <= 1'b1;
            r_div    <= '0;
        end else if (w_clear) begin
            r_code   <= '0;
            r_head_a <= '0;
            r_head_b <= '0;
            r_flash  <= 1'b0;
            r_div    <= '0;
        end else if (r_state == ST_FAULT) begin
            if (r_div == c_DMAX) begin
                r_div   <= '0;
                r_flash <= ~r_flash;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign fault        = (r_state == ST_FAULT);
    assign fault_code   = r_code;
    assign fault_head   = r_head_a;
    assign fault_head_b = r_head_b;
    assign flash        = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_semaforo_monitor
// Brief    : Self-checking bench for semaforo_monitor against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_semaforo_monitor;

    localparam int N    = 14;
    localparam int G    = 2;
    localparam int MINY = 3;
    localparam int MAXS = 64;
    localparam int FDIV = 8;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] GR = 3'b001;
    localparam logic [N-1:0] c_ALLOWED = 14'b11111011011100;

    logic           clk = 1'b0;
    logic           rst;
    logic [3*N-1:0] lights;
    logic [N*N-1:0] map;
    logic           clr;
    logic           fault;
    logic [2:0]     fault_code;
    logic [4:0]     fault_head;
    logic [4:0]     fault_head_b;
    logic           flash;

    int n_assert = 0;
    int n_fail   = 0;

    semaforo_monitor #(
        .N_HEADS   (N),
        .GLITCH_CYC(G),
        .MIN_YELLOW(MINY),
        .MAX_STABLE(MAXS),
        .FLASH_DIV (FDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lights      (lights),
        .conflict_map(map),
        .clr         (clr),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_head  (fault_head),
        .fault_head_b(fault_head_b),
        .flash       (flash)
    );

    always #5 clk = ~clk;

    // Behavioural reference: unbounded run-length counts and fault age
    logic [3*N-1:0] m_q, m_p;
    int             m_crun, m_irun, m_stall, m_age;
    int             m_y [N];
    bit             m_fault, m_flash;
    logic [2:0]     m_code;
    logic [4:0]     m_ha, m_hb;

    function automatic logic [2:0] hd(input logic [3*N-1:0] v, input int h);
        return v[3*h +: 3];
    endfunction

    function automatic bit nonred(input logic [2:0] c);
        return (c == Y) || (c == GR);
    endfunction

    function automatic bit valid(input logic [2:0] c);
        return (c == R) || (c == Y) || (c == GR);
    endfunction

    function automatic logic [14:0] exp_vec();
        return {m_fault, m_code, m_ha, m_hb, m_flash};
    endfunction

    function automatic logic [14:0] obs();
        return {fault, fault_code, fault_head, fault_head_b, flash};
    endfunction

    task automatic m_latch(input logic [2:0] code, input int a, input int b);
        m_fault = 1'b1;
        m_code  = code;
        m_ha    = 5'(a);
        m_hb    = 5'(b);
        m_age   = 0;
        m_flash = 1'b1;
    endtask

    task automatic model_edge();
        bit conf, inv, skp, shy, cleared;
        int ci, cj, ii, si, yi;
        conf = 0; inv = 0; skp = 0; shy = 0; cleared = 0;
        ci = 0; cj = 0; ii = 0; si = 0; yi = 0;
        if (!rst) begin
            m_q = {N{R}}; m_p = {N{R}};
            m_crun = 0; m_irun = 0; m_stall = 0; m_age = 0;
            foreach (m_y[h]) m_y[h] = 0;
            m_fault = 0; m_flash = 0; m_code = '0; m_ha = '0; m_hb = '0;
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = i + 1; j < N; j++)
                    if (!conf && nonred(hd(m_q, i)) && nonred(hd(m_q, j)) &&
                        (map[i*N + j] || map[j*N + i])) begin
                        conf = 1; ci = i; cj = j;
                    end
            for (int h = 0; h < N; h++) begin
                if (!inv && !valid(hd(m_q, h))) begin inv = 1; ii = h; end
                if (!skp && hd(m_p, h) == GR && hd(m_q, h) == R) begin skp = 1; si = h; end
                if (!shy && hd(m_p, h) == Y && hd(m_q, h) == R && m_y[h] < MINY) begin
                    shy = 1; yi = h;
                end
            end
            if (!m_fault) begin
                if (conf && m_crun + 1 >= G)      m_latch(3'd1, ci, cj);
                else if (inv && m_irun + 1 >= G)  m_latch(3'd2, ii, 0);
                else if (skp)                     m_latch(3'd3, si, 0);
                else if (shy)                     m_latch(3'd4, yi, 0);
                else if (m_stall >= MAXS)         m_latch(3'd5, 0, 0);
            end else if (clr && !conf && !inv) begin
                cleared = 1;
                m_fault = 0; m_flash = 0; m_code = '0; m_ha = '0; m_hb = '0;
            end else begin
                m_age++;
                m_flash = ((m_age / FDIV) % 2) == 0;
            end
            if (cleared) begin
                m_crun = 0; m_irun = 0; m_stall = 0;
                foreach (m_y[h]) m_y[h] = 0;
            end else begin
                m_crun  = conf ? m_crun + 1 : 0;
                m_irun  = inv ? m_irun + 1 : 0;
                for (int h = 0; h < N; h++) m_y[h] = (hd(m_q, h) == Y) ? m_y[h] + 1 : 0;
                m_stall = (m_q == m_p) ? m_stall + 1 : 0;
            end
            m_p = m_q;
            m_q = lights;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_h(input int h, input logic [2:0] c);
        lights[3*h +: 3] = c;
    endtask

    task automatic set_std_map();
        map = '0;
        map[0*N + 1] = 1'b1;
        map[0*N + 8] = 1'b1;
        map[5*N + 1] = 1'b1;
        map[8*N + 5] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0; clr = 1'b0; lights = {N{R}};
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_std_map();
        do_reset();
        n_assert++;
        if (obs() !== 15'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        n_assert++;
        if (obs() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h expected %h", obs(), exp_vec());
        end
    endtask

    task automatic test_nominal();
        logic [N-1:0] grp;
        logic [2:0]   c;
        int           ph;
        grp = '0;
        do_reset();
        for (int t = 0; t < 500; t++) begin
            ph = t % 90;
            if (ph == 0) grp = N'($urandom) & c_ALLOWED;
            for (int h = 0; h < N; h++) begin
                c = R;
                if (h == 0 || h == 5)      c = (ph < 31) ? GR : (ph < 35) ? Y : R;
                else if (h == 1 || h == 8) c = (ph >= 35 && ph < 66) ? GR : (ph >= 66 && ph < 70) ? Y : R;
                else if (grp[h])           c = (ph >= 70 && ph < 86) ? GR : (ph >= 86) ? Y : R;
                set_h(h, c);
            end
            tick();
            n_assert++;
            if (fault !== 1'b0 || flash !== 1'b0 || obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL nominal t=%0d: got %h expected %h", t, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_conflict_glitch();
        int age;
        for (int k = 1; k <= 2; k++) begin
            do_reset();
            for (int s = 0; s < 3; s++) begin
                set_h(0, Y);
                set_h(1, (s >= 3 - k) ? GR : R);
                tick();
            end
            set_h(0, R); set_h(1, GR);
            age = -1;
            for (int s = 0; s < 30; s++) begin
                tick();
                if (age >= 0) age++;
                else if (fault === 1'b1) age = 0;
                n_assert++;
                if (obs() !== exp_vec()) begin
                    n_fail++; $display("FAIL glitch k=%0d s=%0d: got %h expected %h", k, s, obs(), exp_vec());
                end
                if (age >= 0) begin
                    n_assert++;
                    if (flash !== (((age / FDIV) % 2) == 0)) begin
                        n_fail++; $display("FAIL flash_period age=%0d: got %b", age, flash);
                    end
                end
            end
            n_assert++;
            if (k == 1 && fault !== 1'b0) begin
                n_fail++; $display("FAIL glitch_short: got fault=%b expected 0", fault);
            end else if (k == 2 && {fault, fault_code, fault_head, fault_head_b} !== {1'b1, 3'd1, 5'd0, 5'd1}) begin
                n_fail++;
                $display("FAIL conflict_latch: got %b %h %0d %0d expected 1 1 0 1",
                         fault, fault_code, fault_head, fault_head_b);
            end
        end
    endtask

    task automatic test_clear_blocked();
        set_h(0, GR); clr = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            n_assert++;
            if (obs() !== exp_vec()) begin
                n_fail++; $display("FAIL clr_blocked s=%0d: got %h expected %h", s, obs(), exp_vec());
            end
        end
        n_assert++;
        if (fault !== 1'b1) begin
            n_fail++; $display("FAIL clr_blocked_hold: got fault=%b expected 1", fault);
        end
        clr = 1'b0; set_h(0, R);
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_assert++;
        if (fault !== 1'b0 || flash !== 1'b0 || fault_code !== 3'd0 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL clr_release: got %h expected %h", obs(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_fault();
        set_h(0, GR);
        for (int s = 0; s < 4; s++) begin
            tick();
            n_assert++;
            if (obs() !== exp_vec()) begin
                n_fail++; $display("FAIL refault s=%0d: got %h expected %h", s, obs(), exp_vec());
            end
        end
        n_assert++;
        if (fault !== 1'b1) begin
            n_fail++; $display("FAIL refault_set: got fault=%b expected 1", fault);
        end
        rst = 1'b0;
        tick();
        n_assert++;
        if (obs() !== 15'd0 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_mid_fault: got %h expected 0", obs());
        end
        rst = 1'b1;
    endtask

    task automatic test_invalid();
        do_reset();
        set_h(0, GR); set_h(1, GR); set_h(3, 3'b110);
        tick(); tick();
        set_h(3, R);
        for (int s = 0; s < 3; s++) tick();
        n_assert++;
        if ({fault_code, fault_head, fault_head_b} !== {3'd1, 5'd0, 5'd1} || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL conflict_over_invalid: got %h expected code 1 heads 0/1", obs());
        end
        do_reset();
        set_h(3, 3'b000);
        tick(); tick();
        set_h(3, R);
        for (int s = 0; s < 3; s++) tick();
        n_assert++;
        if ({fault, fault_code, fault_head, fault_head_b} !== {1'b1, 3'd2, 5'd3, 5'd0} || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL invalid_head: got %h expected code 2 head 3", obs());
        end
    endtask

    task automatic test_yellow_seq();
        do_reset();
        set_h(5, GR); tick();
        set_h(5, Y);  tick(); tick();
        set_h(5, R);
        for (int s = 0; s < 3; s++) tick();
        n_assert++;
        if ({fault, fault_code, fault_head} !== {1'b1, 3'd4, 5'd5} || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL short_yellow: got %h expected code 4 head 5", obs());
        end
        do_reset();
        set_h(5, GR); tick();
        set_h(5, R);
        for (int s = 0; s < 3; s++) tick();
        n_assert++;
        if ({fault, fault_code, fault_head} !== {1'b1, 3'd3, 5'd5} || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL skip_yellow: got %h expected code 3 head 5", obs());
        end
    endtask

    task automatic test_stall();
        int waited;
        do_reset();
        waited = 0;
        while (fault !== 1'b1 && waited < 200) begin
            tick(); waited++;
        end
        n_assert++;
        if (fault !== 1'b1 || fault_code !== 3'd5 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL stall: got %h after %0d cycles expected code 5", obs(), waited);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        n_assert++;
        if (fault !== 1'b0 || obs() !== exp_vec()) begin
            n_fail++; $display("FAIL stall_clear: got %h expected %h", obs(), exp_vec());
        end
        waited = 0;
        while (fault !== 1'b1 && waited < 200) begin
            tick(); waited++;
        end
        n_assert++;
        if (waited != MAXS + 1 || fault_code !== 3'd5) begin
            n_fail++; $display("FAIL stall_restart: got %0d cycles code %h expected %0d cycles code 5",
                               waited, fault_code, MAXS + 1);
        end
    endtask

    task automatic test_random();
        logic [2:0] bad [5];
        int         r;
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        for (int trial = 0; trial < 15; trial++) begin
            rst = 1'b0; clr = 1'b0; lights = {N{R}}; map = '0;
            for (int b = 0; b < 6; b++) map[$urandom_range(0, N*N - 1)] = 1'b1;
            tick(); tick();
            rst = 1'b1;
            for (int c = 0; c < 120; c++) begin
                for (int h = 0; h < N; h++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        r = int'($urandom_range(0, 19));
                        if (r == 0)      set_h(h, bad[$urandom_range(0, 4)]);
                        else if (r < 8)  set_h(h, R);
                        else if (r < 14) set_h(h, Y);
                        else             set_h(h, GR);
                    end
                end
                clr = ($urandom_range(0, 7) == 0);
                tick();
                n_assert++;
                if (obs() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random trial=%0d c=%0d: got %h expected %h", trial, c, obs(), exp_vec());
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; lights = {N{R}}; map = '0;
        test_reset();
        test_nominal();
        test_conflict_glitch();
        test_clear_blocked();
        test_reset_mid_fault();
        set_std_map();
        test_invalid();
        test_yellow_seq();
        test_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
